// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding and default limits for the memory arbiter
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRD   = 2'd2,
      DWR   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_DEF    = 8'd255;
   localparam logic [2:0] FAIR_LIMIT_DEF = 3'd4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, one access at a time
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [7:0] TIMEOUT    = TIMEOUT_DEF,
   parameter logic [2:0] FAIR_LIMIT = FAIR_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_valid,
   input  logic        d_re,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_valid,
   output logic        stall,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rdy,
   output logic        bus_err
);

   state_t      state, state_nx;
   logic [2:0]  fair_cnt;
   logic [7:0]  wait_cnt;
   logic [15:0] addr_q, wdata_q;
   logic        d_req, busy, grant_d, grant_f, timeout, done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         fair_cnt <= '0;
         wait_cnt <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state <= state_nx;
         if (!busy) begin
            wait_cnt <= '0;
            if (grant_d) begin
               addr_q  <= d_addr;
               wdata_q <= d_wdata;
            end else if (grant_f) begin
               addr_q  <= if_addr;
               wdata_q <= '0;
            end
         end else if (!mem_rdy) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         // fetch starvation guard: count data wins only while a fetch is waiting
         if (!if_req || grant_f)
            fair_cnt <= '0;
         else if (grant_d && fair_cnt < FAIR_LIMIT)
            fair_cnt <= fair_cnt + 3'd1;
      end
   end

   always_comb begin
      d_req     = d_re | d_we;
      busy      = state != IDLE;
      grant_d   = !busy && d_req && (!if_req || fair_cnt < FAIR_LIMIT);
      grant_f   = !busy && !grant_d && if_req;
      timeout   = busy && !mem_rdy && wait_cnt == TIMEOUT;
      done      = busy && (mem_rdy || timeout);
      state_nx  = grant_d ? (d_we ? DWR : DRD) : grant_f ? FETCH : done ? IDLE : state;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_re    = state == FETCH || state == DRD;
      mem_we    = state == DWR;
      if_valid  = state == FETCH && done;
      d_valid   = (state == DRD || state == DWR) && done;
      if_rdata  = (if_valid && mem_rdy) ? mem_rdata : '0;
      d_rdata   = (state == DRD && mem_rdy) ? mem_rdata : '0;
      bus_err   = timeout;
      stall     = (if_req & ~if_valid) | (d_req & ~d_valid);
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255, mem_rdy wait limit in cycles.
REQ-002 Parameter: FAIR_LIMIT, default 3'd4, max consecutive data grants while fetch waits.
REQ-003 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst_n  in  1  reset; synchronous and active-low.
REQ-005 Port: if_req  in  1  instruction fetch request, held until if_valid.
REQ-006 Port: if_addr  in  16  fetch address (i_addr).
REQ-007 Port: if_rdata  out  16  fetched instruction.
REQ-008 Port: if_valid  out  1  fetch complete this cycle.
REQ-009 Port: d_re / d_we  in  1 each  data read / write request (decoder Mem_re/Mem_we), held until d_valid; both high treated as write.
REQ-010 Port: d_addr, d_wdata  in  16 each  data address and store data.
REQ-011 Port: d_rdata  out  16  load data; d_valid  out  1  data access complete this cycle.
REQ-012 Port: stall  out  1  pipeline freeze request.
REQ-013 Port: mem_addr, mem_wdata  out  16 each; mem_re, mem_we  out  1 each  shared memory port.
REQ-014 Port: mem_rdata  in  16; mem_rdy  in  1  memory completes current access.
REQ-015 Port: bus_err  out  1  one-cycle pulse on access timeout.

Function
REQ-016 FSM states: IDLE, FETCH, DRD, DWR; exactly one access outstanding at any time.
REQ-017 IDLE: data request pending and (fetch not pending or fair_cnt < FAIR_LIMIT) -> DRD/DWR; else if_req -> FETCH; else stay.
REQ-018 fair_cnt (3 bit) increments on each data grant while if_req high, clears on every fetch grant or when if_req low, saturates at FAIR_LIMIT.
REQ-019 On grant, address/wdata/direction latch into registers; mem_* driven only from these registers, constant for whole access.
REQ-020 mem_re high only in FETCH or DRD; mem_we high only in DWR; never both; both low in IDLE.
REQ-021 In FETCH/DRD/DWR with mem_rdy=1: matching valid high same cycle, rdata = mem_rdata combinationally (d_rdata for DRD only), next state IDLE.
REQ-022 Minimum latency: request seen in IDLE at cycle N -> valid at N+1 with mem_rdy=1; one IDLE bubble between back-to-back accesses.
REQ-023 if_rdata/d_rdata = 16'h0000 when respective valid low.
REQ-024 wait_cnt (8 bit) clears on grant, increments each busy cycle with mem_rdy=0; reaching TIMEOUT -> bus_err pulse, valid asserted with rdata 16'h0000, state IDLE.
REQ-025 stall = (if_req & ~if_valid) | ((d_re|d_we) & ~d_valid).
REQ-026 Request dropped mid-access: access still completes on memory; valid still pulses; arbiter ignores drop.
REQ-027 mem_rdy while IDLE ignored.

Reset
REQ-028 rst_n=0 at a rising edge: state IDLE, fair_cnt 0, wait_cnt 0, latched addr/wdata 0, all outputs 0 next cycle.
REQ-029 Reset mid-access abandons access; no valid or bus_err pulse for it; mem_re/mem_we low the cycle after reset.

Structure
REQ-030 Shared package holds FSM state encoding (2-bit IDLE=0, FETCH=1, DRD=2, DWR=3) and TIMEOUT/FAIR_LIMIT defaults.
REQ-031 Single module; no sub-module; one sequential block for state/counters/latches, one combinational block for next-state and outputs.

Verification
REQ-032 if_req, if_addr=16'h0040, mem_rdy tied 1, mem_rdata=16'hB123 -> mem_re with mem_addr 16'h0040 cycle after request; if_valid one cycle, if_rdata=16'hB123.
REQ-033 if_req and d_re (d_addr 16'h1000) same cycle -> DRD granted first, then FETCH; stall high until both valids seen.
REQ-034 d_we, d_addr=16'h2000, d_wdata=16'h5A5A, mem_rdy low 3 cycles -> mem_we/addr/wdata stable 4 cycles, d_valid on cycle mem_rdy rises.
REQ-035 Continuous data requests plus if_req -> FETCH granted after exactly 4 data grants; fair_cnt back to 0.
REQ-036 d_re with mem_rdy held 0 -> bus_err and d_valid pulse after 255 wait cycles, d_rdata 16'h0000, FSM IDLE.
REQ-037 rst_n low during FETCH wait -> next cycle mem_re 0, if_valid 0, state IDLE; new if_req served normally afterwards.
